// File: rtl/ct_spsram_1024x128_arb.sv
// Two-port round-robin front end for a single-port 1024x128 SRAM macro.
// Define CT_SPSRAM_ARB_INIT_EN to zero-fill the array after every reset.
module ct_spsram_1024x128_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_wmask,
  output logic                  p0_gnt,
  output logic                  p0_rvld,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wmask,
  output logic                  p1_gnt,
  output logic                  p1_rvld,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  prio_q, prio_d;  // 1 = p1 wins the next contention
  logic [1:0]            rvld_q, rvld_d;
  logic                  accept;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_a;

`ifdef CT_SPSRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    if (state_q == ST_INIT) begin
      init_wr = !RST;
      cnt_d   = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_a    = cnt_q;
  assign accept    = !RST && (state_q == ST_IDLE);
  assign init_done = accept;
`else
  assign init_wr   = 1'b0;
  assign init_a    = '0;
  assign accept    = !RST;
  assign init_done = 1'b1;
`endif

  // Priority port wins only on contention; a lone requester is always served.
  assign p0_gnt = accept && p0_req && (!p1_req || !prio_q);
  assign p1_gnt = accept && p1_req && (!p0_req ||  prio_q);

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    prio_d    = prio_q;
    rvld_d    = 2'b00;
    if (p0_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = p0_addr;
      prio_d    = 1'b1;
      rvld_d[0] = !p0_wr;
      if (p0_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~p0_wmask;
        sram_d    = p0_wdata;
      end
    end else if (p1_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = p1_addr;
      prio_d    = 1'b0;
      rvld_d[1] = !p1_wr;
      if (p1_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~p1_wmask;
        sram_d    = p1_wdata;
      end
    end else if (init_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_a;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= 1'b0;
      rvld_q <= 2'b00;
    end else begin
      prio_q <= prio_d;
      rvld_q <= rvld_d;
    end
  end

  // The macro's read data lands one cycle after the access; steer it to the reader.
  assign p0_rvld  = rvld_q[0] && !RST;
  assign p1_rvld  = rvld_q[1] && !RST;
  assign p0_rdata = p0_rvld ? sram_q : '0;
  assign p1_rdata = p1_rvld ? sram_q : '0;

endmodule

// File: tb/tb_ct_spsram_1024x128_arb.sv
// Directed bench for ct_spsram_1024x128_arb with a behavioural SRAM macro model.
// Exercises the zero-fill sequence too when CT_SPSRAM_ARB_INIT_EN is defined.
module tb_ct_spsram_1024x128_arb;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
  logic [9:0]   p0_addr = '0, p1_addr = '0;
  logic [127:0] p0_wdata = '0, p0_wmask = '0, p1_wdata = '0, p1_wmask = '0;
  logic         p0_gnt, p0_rvld, p1_gnt, p1_rvld, init_done;
  logic [127:0] p0_rdata, p1_rdata;
  logic         sram_cen, sram_gwen;
  logic [127:0] sram_wen, sram_d, sram_q;
  logic [9:0]   sram_a;

  int total = 0;
  int bad   = 0;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam logic DONE_AFTER_RST = 1'b0;
`else
  localparam logic DONE_AFTER_RST = 1'b1;
`endif
  localparam logic [127:0] PAT_A5   = {16{8'hA5}};
  localparam logic [127:0] MASK_RES = {{120{1'b1}}, 8'h00};

  ct_spsram_1024x128_arb dut (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_gnt(p0_gnt), .p0_rvld(p0_rvld), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_gnt(p1_gnt), .p1_rvld(p1_rvld), .p1_rdata(p1_rdata),
    .init_done(init_done), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  // Single-port SRAM: bit-masked write, read data registered one cycle later.
  logic [127:0] mem [0:1023];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (init_done !== 1'b1 && n < 2000) begin @(negedge CLK); #1; n++; end
    total++; if (init_done !== 1'b1) begin $display("FAIL wait_ready init_done=%b want 1", init_done); bad++; end
  endtask

  task automatic test_reset();
    RST = 1'b1; p0_req = 1; p1_req = 1; p0_wr = 0; p1_wr = 1;
    @(negedge CLK); #1;
    total++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin $display("FAIL rst_gnt got=%b%b want 00", p0_gnt, p1_gnt); bad++; end
    total++; if (sram_cen !== 1'b1 || sram_gwen !== 1'b1) begin $display("FAIL rst_cen got cen=%b gwen=%b want 1 1", sram_cen, sram_gwen); bad++; end
    total++; if (sram_wen !== '1) begin $display("FAIL rst_wen got=%h want all ones", sram_wen); bad++; end
    total++; if (init_done !== DONE_AFTER_RST) begin $display("FAIL rst_init_done got=%b want %b", init_done, DONE_AFTER_RST); bad++; end
    @(negedge CLK); RST = 1'b0; p0_req = 0; p1_req = 0; #1;
    total++; if (p0_rvld !== 1'b0 || p1_rvld !== 1'b0 || p0_rdata !== '0 || p1_rdata !== '0) begin
      $display("FAIL post_rst_rvld got rvld=%b%b rdata0=%h want 0", p0_rvld, p1_rvld, p0_rdata); bad++; end
    total++; if (init_done !== DONE_AFTER_RST) begin $display("FAIL post_rst_init_done got=%b want %b", init_done, DONE_AFTER_RST); bad++; end
`ifndef CT_SPSRAM_ARB_INIT_EN
    total++; if (sram_cen !== 1'b1) begin $display("FAIL post_rst_cen got=%b want 1", sram_cen); bad++; end
`endif
    $display("reset test complete");
  endtask

`ifdef CT_SPSRAM_ARB_INIT_EN
  task automatic check_full_init(input string name);
    int errs = 0;
    for (int i = 0; i < 1024; i++) begin
      #1;
      if (sram_a !== i[9:0] || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
          sram_d !== '0 || p0_gnt !== 1'b0 || init_done !== 1'b0) errs++;
      @(negedge CLK);
    end
    #1;
    total++; if (errs != 0) begin $display("FAIL %s_seq bad_cycles=%0d want 0", name, errs); bad++; end
    total++; if (init_done !== 1'b1) begin $display("FAIL %s_done got=%b want 1", name, init_done); bad++; end
    total++; if (p0_gnt !== 1'b1) begin $display("FAIL %s_gnt_after got=%b want 1", name, p0_gnt); bad++; end
    $display("%s: 1024 zero-fill cycles checked", name);
  endtask

  task automatic test_init();
    p0_req = 1; p0_wr = 0; p0_addr = 10'h001;
    do_reset();
    check_full_init("init");
    p0_req = 0;
  endtask

  task automatic test_init_restart();
    do_reset();
    repeat (500) @(negedge CLK);
    #1;
    total++; if (sram_a !== 10'd500) begin $display("FAIL restart_cnt got=%0d want 500", sram_a); bad++; end
    RST = 1'b1; #1;
    total++; if (sram_cen !== 1'b1) begin $display("FAIL restart_rst_cen got=%b want 1", sram_cen); bad++; end
    @(negedge CLK); RST = 1'b0;
    p0_req = 1; p0_wr = 0;
    check_full_init("restart");
    p0_req = 0;
  endtask
`endif

  task automatic test_idle_outputs();
    @(negedge CLK); p0_req = 0; p1_req = 0; #1;
    total++; if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== '1 || sram_a !== '0 || sram_d !== '0) begin
      $display("FAIL idle_sram got cen=%b gwen=%b a=%h d=%h want 1 1 0 0", sram_cen, sram_gwen, sram_a, sram_d); bad++; end
    $display("idle outputs checked");
  endtask

  task automatic test_write_read();
    @(negedge CLK);
    p0_req = 1; p0_wr = 1; p0_addr = 10'h155; p0_wdata = PAT_A5; p0_wmask = '1; #1;
    total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin $display("FAIL wr_gnt got=%b%b want 10", p0_gnt, p1_gnt); bad++; end
    total++; if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 10'h155 || sram_wen !== '0 || sram_d !== PAT_A5) begin
      $display("FAIL wr_sram got cen=%b gwen=%b a=%h d=%h want 0 0 155 %h", sram_cen, sram_gwen, sram_a, sram_d, PAT_A5); bad++; end
    @(negedge CLK);
    p0_req = 0; p1_req = 1; p1_wr = 0; p1_addr = 10'h155; #1;
    total++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin $display("FAIL rd_gnt got=%b%b want 01", p0_gnt, p1_gnt); bad++; end
    total++; if (sram_gwen !== 1'b1 || sram_wen !== '1) begin $display("FAIL rd_sram got gwen=%b want 1", sram_gwen); bad++; end
    total++; if (p0_rvld !== 1'b0) begin $display("FAIL wr_no_rvld got=%b want 0", p0_rvld); bad++; end
    @(negedge CLK); p1_req = 0; #1;
    total++; if (p1_rvld !== 1'b1 || p1_rdata !== PAT_A5) begin $display("FAIL rd_data got rvld=%b data=%h want 1 %h", p1_rvld, p1_rdata, PAT_A5); bad++; end
    total++; if (p0_rvld !== 1'b0 || p0_rdata !== '0) begin $display("FAIL rd_other got rvld=%b data=%h want 0 0", p0_rvld, p0_rdata); bad++; end
    @(negedge CLK); #1;
    total++; if (p1_rvld !== 1'b0 || p1_rdata !== '0) begin $display("FAIL rd_one_cycle got rvld=%b data=%h want 0 0", p1_rvld, p1_rdata); bad++; end
    $display("write 0x155 then read via p1 checked");
  endtask

  task automatic test_round_robin();
    logic e0;
    @(negedge CLK);
    p0_req = 1; p0_wr = 0; p0_addr = 10'h155;
    p1_req = 1; p1_wr = 0; p1_addr = 10'h155;
    for (int c = 0; c < 6; c++) begin
      #1;
      e0 = (c % 2 == 0);
      total++; if (p0_gnt !== e0 || p1_gnt !== !e0) begin $display("FAIL rr_gnt%0d got=%b%b want %b%b", c, p0_gnt, p1_gnt, e0, !e0); bad++; end
      if (c > 0) begin
        total++; if (p0_rvld !== !e0 || p1_rvld !== e0 || (e0 ? p1_rdata : p0_rdata) !== PAT_A5) begin
          $display("FAIL rr_rvld%0d got=%b%b want %b%b", c, p0_rvld, p1_rvld, !e0, e0); bad++; end
      end
      $display("rr cycle %0d gnt=%b%b rvld=%b%b", c, p0_gnt, p1_gnt, p0_rvld, p1_rvld);
      @(negedge CLK);
    end
    p0_req = 0; p1_req = 0; #1;
    total++; if (p0_rvld !== 1'b0 || p1_rvld !== 1'b1) begin $display("FAIL rr_last_rvld got=%b%b want 01", p0_rvld, p1_rvld); bad++; end
  endtask

  task automatic test_mask();
    @(negedge CLK);
    p0_req = 1; p0_wr = 1; p0_addr = 10'h3FF; p0_wdata = '1; p0_wmask = '1; #1;
    total++; if (p0_gnt !== 1'b1) begin $display("FAIL mask_wr1_gnt got=%b want 1", p0_gnt); bad++; end
    @(negedge CLK); p0_wdata = '0; p0_wmask = 128'hFF; #1;
    total++; if (sram_wen !== MASK_RES) begin $display("FAIL mask_wen got=%h want %h", sram_wen, MASK_RES); bad++; end
    @(negedge CLK); p0_wr = 0; #1;
    total++; if (p0_gnt !== 1'b1 || sram_gwen !== 1'b1) begin $display("FAIL mask_rd_gnt got=%b gwen=%b want 1 1", p0_gnt, sram_gwen); bad++; end
    @(negedge CLK); p0_req = 0; #1;
    total++; if (p0_rvld !== 1'b1 || p0_rdata !== MASK_RES) begin $display("FAIL mask_data got=%h want %h", p0_rdata, MASK_RES); bad++; end
    $display("masked write to 0x3FF checked");
  endtask

  task automatic test_rvld_reset();
    @(negedge CLK); p0_req = 1; p0_wr = 0; p0_addr = 10'h155; #1;
    total++; if (p0_gnt !== 1'b1) begin $display("FAIL rr_rst_gnt got=%b want 1", p0_gnt); bad++; end
    @(negedge CLK); p0_req = 0; RST = 1'b1; #1;
    total++; if (p0_rvld !== 1'b0 || p0_rdata !== '0) begin $display("FAIL rvld_in_rst got rvld=%b data=%h want 0 0", p0_rvld, p0_rdata); bad++; end
    @(negedge CLK); RST = 1'b0; #1;
    total++; if (p0_rvld !== 1'b0) begin $display("FAIL rvld_dropped got=%b want 0", p0_rvld); bad++; end
    wait_ready();
    @(negedge CLK);
    p0_req = 1; p0_wr = 0; p1_req = 1; p1_wr = 0; #1;
    total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin $display("FAIL ptr_reset got=%b%b want 10", p0_gnt, p1_gnt); bad++; end
    @(negedge CLK); p0_req = 0; p1_req = 0;
    $display("reset with pending rvld checked");
  endtask

  initial begin
    test_reset();
`ifdef CT_SPSRAM_ARB_INIT_EN
    test_init();
    test_init_restart();
`endif
    wait_ready();
    test_idle_outputs();
    test_write_read();
    test_round_robin();
    test_mask();
    test_rvld_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
